// File: rtl/fog_step_readout_if.sv
// Bus between the FOG step reader and its neighbours: step input, CPU pop handshake, status.
// o_tstamp exists only when FOG_READOUT_TSTAMP_EN is defined.
interface fog_step_readout_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 5
);
  logic              i_en;
  logic              i_trig;
  logic [DATA_W-1:0] i_data;
  logic [3:0]        i_dec_sel;
  logic              i_rd_en;
  logic              i_clr_ovf;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic [CNT_W-1:0]  o_count;
  logic              o_overflow;
  logic [15:0]       o_drop_cnt;
`ifdef FOG_READOUT_TSTAMP_EN
  logic [31:0]       o_tstamp;
`endif

  modport master (
`ifdef FOG_READOUT_TSTAMP_EN
    input  o_tstamp,
`endif
    output i_en, i_trig, i_data, i_dec_sel, i_rd_en, i_clr_ovf,
    input  o_data, o_valid, o_count, o_overflow, o_drop_cnt
  );

  modport slave (
`ifdef FOG_READOUT_TSTAMP_EN
    output o_tstamp,
`endif
    input  i_en, i_trig, i_data, i_dec_sel, i_rd_en, i_clr_ovf,
    output o_data, o_valid, o_count, o_overflow, o_drop_cnt
  );
endinterface

// File: rtl/fog_step_readout.sv
// FOG feedback-step reader: averages 2^sel step samples and queues results in a FWFT FIFO.
// Optional FOG_READOUT_TSTAMP_EN stores an EMIT-cycle timestamp with each FIFO entry.
module fog_step_readout #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_SEL    = 10,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 5
) (
  input logic               i_clk,
  input logic               i_rst,
  fog_step_readout_if.slave bus
);

  localparam int unsigned AccW  = DATA_W + MAX_SEL;
  localparam int unsigned WcntW = MAX_SEL + 1;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StAccum, StEmit} state_e;

  state_e                 state_q, state_d;
  logic signed [AccW-1:0] acc_q, acc_d;
  logic [WcntW-1:0]       cnt_q, cnt_d;
  logic [3:0]             sel_q, sel_d;
  logic [DATA_W-1:0]      avg_q, avg_d;

  logic [3:0]             sel_in;
  logic [3:0]             sel_eff;
  logic signed [AccW-1:0] acc_base;
  logic signed [AccW-1:0] acc_sum;
  logic signed [AccW-1:0] rnd_inc;
  logic signed [AccW-1:0] rnd_sum;
  logic signed [AccW-1:0] shifted;
  logic [WcntW-1:0]       cnt_base;
  logic [WcntW-1:0]       cnt_sum;
  logic                   win_done;

  always_comb begin
    sel_in = (bus.i_dec_sel > 4'(MAX_SEL)) ? 4'(MAX_SEL) : bus.i_dec_sel;
  end

  // In EMIT the window restarts from zero with a freshly latched exponent, so a trigger
  // landing in EMIT is folded in as the first sample of the new window.
  always_comb begin
    if (state_q == StEmit) begin
      acc_base = '0;
      cnt_base = '0;
      sel_eff  = sel_in;
    end else begin
      acc_base = acc_q;
      cnt_base = cnt_q;
      sel_eff  = sel_q;
    end
    acc_sum  = acc_base + {{MAX_SEL{bus.i_data[DATA_W-1]}}, bus.i_data};
    cnt_sum  = cnt_base + WcntW'(1);
    win_done = (cnt_sum == (WcntW'(1) << sel_eff));
    rnd_inc  = (sel_eff == 4'd0) ? '0 : (AccW'(1) << (sel_eff - 4'd1));
    rnd_sum  = acc_sum + rnd_inc;
    shifted  = rnd_sum >>> sel_eff;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    avg_d   = avg_q;
    unique case (state_q)
      StIdle: begin
        acc_d = '0;
        cnt_d = '0;
        if (bus.i_en) begin
          state_d = StAccum;
          sel_d   = sel_in;
        end
      end
      StAccum, StEmit: begin
        if (state_q == StEmit) begin
          sel_d = sel_in;
        end
        if (!bus.i_en) begin
          state_d = StIdle;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (bus.i_trig && win_done) begin
          state_d = StEmit;
          avg_d   = shifted[DATA_W-1:0];
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = StAccum;
          acc_d   = bus.i_trig ? acc_sum : acc_base;
          cnt_d   = bus.i_trig ? cnt_sum : cnt_base;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      avg_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      avg_q   <= avg_d;
    end
  end

  // FIFO
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              wr_req, full, empty, pop, wr_ok, drop;

  always_comb begin
    wr_req = (state_q == StEmit);
    full   = (count_q == CNT_W'(FIFO_DEPTH));
    empty  = (count_q == '0);
    pop    = bus.i_rd_en && !empty;
    wr_ok  = wr_req && (!full || pop);
    drop   = wr_req && full && !pop;

    count_d = count_q;
    if (wr_ok && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !wr_ok) begin
      count_d = count_q - CNT_W'(1);
    end

    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    // A clear on the same edge as a drop wins outright.
    if (bus.i_clr_ovf) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= avg_q;
    end
  end

  // Storage is not reset, so the head is masked until an entry is present.
  always_comb begin
    bus.o_valid    = !empty;
    bus.o_data     = empty ? '0 : mem_q[rd_ptr_q];
    bus.o_count    = count_q;
    bus.o_overflow = ovf_q;
    bus.o_drop_cnt = drop_cnt_q;
  end

`ifdef FOG_READOUT_TSTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] ts_mem_q [FIFO_DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_ok) begin
      ts_mem_q[wr_ptr_q] <= ts_q;
    end
  end

  always_comb begin
    bus.o_tstamp = empty ? '0 : ts_mem_q[rd_ptr_q];
  end
`endif

endmodule

// File: doc/fog_step_readout.md
Name: fog_step_readout

Overview:
- Reader side of the FOG loop's feedback-step output: consumes the one-cycle step trigger and the signed 32-bit step value the FOG core writes each loop cycle.
- Averages the step value over 2^N triggers (decimation), then buffers the results in a first-word-fall-through FIFO.
- The CPU bridge pops results with a valid/read-enable handshake, so the CPU reads at its own pace without missing loop updates.
- Sits between the FOG core outputs and the CPU register bridge, in the DAC clock domain.

Parameters:
DATA_W, 32, width of input step and output average (signed)
MAX_SEL, 10, largest decimation exponent accepted
FIFO_DEPTH, 16, FIFO entries (power of two, >=2)
CNT_W, 5, width of o_count (log2(FIFO_DEPTH)+1)

Ports:
i_clk  in  1  single clock (FOG DAC clock)
i_rst  in  1  reset, asynchronous, active-high
i_en  in  1  capture enable; low = accumulator idle, FIFO still readable
i_trig  in  1  one-cycle pulse marking a new valid i_data (step sync)
i_data  in  DATA_W  signed step sample, sampled when i_trig=1
i_dec_sel  in  4  decimation exponent; window = 2^sel triggers, values >MAX_SEL clamp to MAX_SEL
i_rd_en  in  1  pop head entry; ignored when o_valid=0
i_clr_ovf  in  1  clears o_overflow and o_drop_cnt
o_data  out  DATA_W  FIFO head (averaged step), valid when o_valid=1
o_valid  out  1  FIFO non-empty
o_count  out  CNT_W  entries in FIFO
o_overflow  out  1  sticky: a result was dropped because the FIFO was full
o_drop_cnt  out  16  dropped results, saturating at 0xFFFF

Behaviour:
- Reset (async, i_rst=1) behaviour:
  - All outputs go to 0 and the FIFO empties.
  - The accumulator and window counter clear, and the FSM enters IDLE.
  - Reset asserted mid-window discards the partial sum; reset asserted mid-read discards FIFO contents.
- FSM states:
  - IDLE: accumulator=0, count=0. Moves to ACCUM when i_en=1. i_trig is ignored in IDLE.
  - ACCUM: on each i_trig, acc += sign-extended i_data and cnt++.
    - When the sample taken makes cnt == 2^sel_lat, the FSM moves to EMIT.
    - i_en=0 moves to IDLE and discards the partial window.
  - EMIT (one cycle): the registered average is written to the FIFO.
    - Then acc=0, cnt=0, and i_dec_sel is re-latched.
    - Returns to ACCUM, or to IDLE if i_en=0.
    - An i_trig arriving in EMIT is counted as the first sample of the next window; it is not lost.
- sel_lat latch and accumulator width:
  - sel_lat is latched on IDLE->ACCUM and at each EMIT. A change of i_dec_sel mid-window takes effect from the next window.
  - Accumulator width is DATA_W+MAX_SEL (42 bits) and cannot overflow.
- Average computation:
  - For sel_lat=0: avg = acc.
  - Otherwise: avg = (acc + 2^(sel_lat-1)) >>> sel_lat, arithmetic shift with round-half-up, truncated to DATA_W.
  - The rounded mean of DATA_W signed values always fits in DATA_W; bench checks there is no wrap.
- Latency:
  - The edge sampling the final i_trig of a window loads avg.
  - The next edge (EMIT) writes the FIFO.
  - With the FIFO previously empty, o_valid and o_data are valid after that second edge.
- FIFO behaviour:
  - First-word-fall-through: o_data always shows the head entry.
  - A pop on a clock edge with i_rd_en=1 and o_valid=1 advances the head; o_count updates the same edge.
- Full and empty conditions:
  - Write while full with no pop on the same edge: the result is dropped, o_overflow is set and o_drop_cnt increments, saturating at 0xFFFF.
  - Write and pop on the same edge while full: both succeed, nothing is dropped and o_count is unchanged.
  - Write and pop on the same edge while empty: the pop is ignored because o_valid=0, and the write succeeds.
- i_clr_ovf has priority over a simultaneous drop: the clear wins and the counter reads 0.
- Read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. o_count is derived from a separate up/down counter.

Optional Feature:
FOG_READOUT_TSTAMP_EN
- Defined:
  - Adds output o_tstamp (32 bits) and an internal free-running 32-bit cycle counter, reset to 0, wrapping 0xFFFFFFFF->0.
  - The counter value at the EMIT cycle is stored alongside each FIFO entry.
  - o_tstamp presents the head entry's timestamp, is qualified by o_valid, and is 0 after reset.
- Undefined: no port, no counter, no extra FIFO storage.

Test Plan:
- i_dec_sel=2, i_en=1, trig pulses with i_data 10,11,12,13 -> one entry, o_data=12 ((46+2)>>2), o_valid rises 2 edges after the 4th trig sample, o_count=1.
- i_dec_sel=1, data -3,-4 -> o_data=-3 ((-7+1)>>>1); data 0x7FFFFFFF twice -> o_data=0x7FFFFFFF, no wrap.
- i_dec_sel=0, 18 trigs, no reads -> o_count=16, o_overflow=1, o_drop_cnt=2; pulse i_clr_ovf -> both 0, FIFO unchanged; 16 pops return the first 16 samples in order.
- FIFO full, i_rd_en=1 on the same edge as EMIT write -> o_count stays 16, no drop, new entry becomes the tail.
- i_dec_sel changed 3->0 after 5 of 8 trigs -> the first window still averages 8 samples; the following trigs produce one entry each.
- i_rst pulsed after 2 of 4 trigs with 3 FIFO entries -> o_valid=0, o_count=0; after release, 4 new trigs yield exactly one correct average. i_en dropped mid-window -> no entry is written.
